// File: rtl/rate_mon_pkg.sv
// -----------------------------------------------------------------------------
// rate_mon_pkg
// Shared definitions for the RX rate monitor:
//   - ch_state_e : per-channel frame state (IDLE, IN_FRAME)
//   - MAX_CH     : largest supported channel count / read-port address space
//   - MAX_CNT_W  : widest supported counter
//   - sat_inc()  : saturating increment used by every counter
// Optional feature macro used by the users of this package: RATE_MON_PEAK_EN.
// -----------------------------------------------------------------------------
package rate_mon_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_CNT_W = 48;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } ch_state_e;

    // Increment value by one when en is set, holding at max_value instead of
    // wrapping. Operands are carried at the widest counter width; callers
    // zero-extend their counter and pass their own all-ones limit.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] value,
        input logic [MAX_CNT_W-1:0] max_value,
        input logic                 en
    );
        logic [MAX_CNT_W-1:0] result;
        if (en && (value != max_value)) begin
            result = value + 48'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/rate_mon_channel.sv
// -----------------------------------------------------------------------------
// rate_mon_channel
// One monitored RX channel: live byte/frame/errored-frame counters, the
// errored-frame latch, the IDLE/IN_FRAME state machine and the per-window
// snapshots.
// Ports:
//   clk125MHz, rstn  : clock, asynchronous active-low reset
//   clear            : synchronous restart (live counters, latch, state, peak)
//   tick             : last cycle of the current window
//   rx_en, rx_err    : byte strobe and error flag for this channel
//   snap_bytes/frames/errs : counts captured at the last tick
//   peak             : largest bytes snapshot since reset/clear
//                      (only when RATE_MON_PEAK_EN is defined)
// -----------------------------------------------------------------------------
module rate_mon_channel
    import rate_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk125MHz,
    input  logic             rstn,
    input  logic             clear,
    input  logic             tick,
    input  logic             rx_en,
    input  logic             rx_err,
    output logic [CNT_W-1:0] snap_bytes,
    output logic [CNT_W-1:0] snap_frames,
`ifdef RATE_MON_PEAK_EN
    output logic [CNT_W-1:0] snap_errs,
    output logic [CNT_W-1:0] peak
`else
    output logic [CNT_W-1:0] snap_errs
`endif
);

    localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'({CNT_W{1'b1}});

    ch_state_e        state_r;
    logic             ef_r;
    logic [CNT_W-1:0] bytes_r;
    logic [CNT_W-1:0] frames_r;
    logic [CNT_W-1:0] errs_r;
    logic [CNT_W-1:0] snap_bytes_r;
    logic [CNT_W-1:0] snap_frames_r;
    logic [CNT_W-1:0] snap_errs_r;

    logic             frame_start_s;
    logic             frame_end_s;
    logic             err_inc_s;
    logic [CNT_W-1:0] bytes_nxt_s;
    logic [CNT_W-1:0] frames_nxt_s;
    logic [CNT_W-1:0] errs_nxt_s;

    // Frame edge detection from the state machine and next-count values.
    // The state doubles as the previous-cycle rx_en, so frames spanning a
    // window boundary keep their history. At a frame end rx_en is 0, so the
    // current-cycle error term cannot contribute; only the latch matters.
    always_comb begin
        frame_start_s = 1'b0;
        frame_end_s   = 1'b0;
        case (state_r)
            IDLE:     frame_start_s = rx_en;
            IN_FRAME: frame_end_s   = ~rx_en;
            default: begin
                frame_start_s = 1'b0;
                frame_end_s   = 1'b0;
            end
        endcase
        err_inc_s    = frame_end_s & (ef_r | (rx_en & rx_err));
        bytes_nxt_s  = CNT_W'(sat_inc(MAX_CNT_W'(bytes_r),  CNT_MAX, rx_en));
        frames_nxt_s = CNT_W'(sat_inc(MAX_CNT_W'(frames_r), CNT_MAX, frame_start_s));
        errs_nxt_s   = CNT_W'(sat_inc(MAX_CNT_W'(errs_r),   CNT_MAX, err_inc_s));
    end

    // Frame state machine and errored-frame latch; neither is touched by tick.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            ef_r    <= 1'b0;
        end else if (clear) begin
            state_r <= IDLE;
            ef_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rx_en) state_r <= IN_FRAME;
                    else       state_r <= IDLE;
                end
                IN_FRAME: begin
                    if (!rx_en) state_r <= IDLE;
                    else        state_r <= IN_FRAME;
                end
                default: state_r <= IDLE;
            endcase
            if (frame_end_s) begin
                ef_r <= 1'b0;
            end else if (rx_en && rx_err) begin
                ef_r <= 1'b1;
            end else begin
                ef_r <= ef_r;
            end
        end
    end

    // Live counters: restart at window end, otherwise accumulate.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            bytes_r  <= {CNT_W{1'b0}};
            frames_r <= {CNT_W{1'b0}};
            errs_r   <= {CNT_W{1'b0}};
        end else if (clear || tick) begin
            bytes_r  <= {CNT_W{1'b0}};
            frames_r <= {CNT_W{1'b0}};
            errs_r   <= {CNT_W{1'b0}};
        end else begin
            bytes_r  <= bytes_nxt_s;
            frames_r <= frames_nxt_s;
            errs_r   <= errs_nxt_s;
        end
    end

    // Snapshots take the next-count values so the tick cycle's own byte,
    // frame start or frame end lands in the closing window. clear wins over
    // tick and leaves the old snapshot in place.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            snap_bytes_r  <= {CNT_W{1'b0}};
            snap_frames_r <= {CNT_W{1'b0}};
            snap_errs_r   <= {CNT_W{1'b0}};
        end else if (tick && !clear) begin
            snap_bytes_r  <= bytes_nxt_s;
            snap_frames_r <= frames_nxt_s;
            snap_errs_r   <= errs_nxt_s;
        end else begin
            snap_bytes_r  <= snap_bytes_r;
            snap_frames_r <= snap_frames_r;
            snap_errs_r   <= snap_errs_r;
        end
    end

    assign snap_bytes  = snap_bytes_r;
    assign snap_frames = snap_frames_r;
    assign snap_errs   = snap_errs_r;

`ifdef RATE_MON_PEAK_EN
    logic [CNT_W-1:0] peak_r;

    // Running maximum of the bytes snapshot, compared against the value
    // being captured in this tick.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            peak_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            peak_r <= {CNT_W{1'b0}};
        end else if (tick && (bytes_nxt_s > peak_r)) begin
            peak_r <= bytes_nxt_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign peak = peak_r;
`endif

endmodule

// File: rtl/rx_rate_monitor.sv
// -----------------------------------------------------------------------------
// rx_rate_monitor
// Per-channel RX throughput / frame-statistics monitor. Every WINDOW_CYCLES
// clocks the live counters of each channel are captured into snapshots that
// are read back through a registered mux selected by rd_ch.
// Optional feature macro: RATE_MON_PEAK_EN (adds per-channel peak register
// and the snap_peak port).
// Ports:
//   clk125MHz, rstn : sole clock, asynchronous active-low reset
//   clear           : synchronous restart of window and live counters
//   rx_en, rx_err   : per-channel byte strobe / error flag [N_CH]
//   rd_ch           : snapshot read channel select (>= N_CH reads zero)
//   snap_bytes/frames/errs : selected channel's last-window counts (1-cycle latency)
//   snap_peak       : selected channel's peak bytes (RATE_MON_PEAK_EN only)
//   snap_valid      : a window has completed since reset/clear
//   window_done     : one-cycle pulse, new snapshots available
// -----------------------------------------------------------------------------
module rx_rate_monitor
    import rate_mon_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int CNT_W         = 32,
    parameter int WINDOW_CYCLES = 125000000
) (
    input  logic             clk125MHz,
    input  logic             rstn,
    input  logic             clear,
    input  logic [N_CH-1:0]  rx_en,
    input  logic [N_CH-1:0]  rx_err,
    input  logic [3:0]       rd_ch,
    output logic [CNT_W-1:0] snap_bytes,
    output logic [CNT_W-1:0] snap_frames,
    output logic [CNT_W-1:0] snap_errs,
`ifdef RATE_MON_PEAK_EN
    output logic [CNT_W-1:0] snap_peak,
`endif
    output logic             snap_valid,
    output logic             window_done
);

    localparam int                WCNT_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW_CYCLES - 1);

    logic [WCNT_W-1:0] wcnt_r;
    logic              tick_s;
    logic              snap_valid_r;
    logic              window_done_r;
    logic [CNT_W-1:0]  snap_bytes_r;
    logic [CNT_W-1:0]  snap_frames_r;
    logic [CNT_W-1:0]  snap_errs_r;

    // Padded to the full 4-bit address space; unpopulated slots read zero.
    logic [CNT_W-1:0]  ch_bytes_s  [MAX_CH];
    logic [CNT_W-1:0]  ch_frames_s [MAX_CH];
    logic [CNT_W-1:0]  ch_errs_s   [MAX_CH];

    assign tick_s = (wcnt_r == WCNT_LAST);

    // Window counter, 0..WINDOW_CYCLES-1.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            wcnt_r <= {WCNT_W{1'b0}};
        end else if (clear || tick_s) begin
            wcnt_r <= {WCNT_W{1'b0}};
        end else begin
            wcnt_r <= wcnt_r + WCNT_W'(1);
        end
    end

    // Window status flags; clear suppresses a coincident tick.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            window_done_r <= 1'b0;
            snap_valid_r  <= 1'b0;
        end else if (clear) begin
            window_done_r <= 1'b0;
            snap_valid_r  <= 1'b0;
        end else begin
            window_done_r <= tick_s;
            snap_valid_r  <= snap_valid_r | tick_s;
        end
    end

`ifdef RATE_MON_PEAK_EN
    logic [CNT_W-1:0] ch_peak_s [MAX_CH];
    logic [CNT_W-1:0] snap_peak_r;
`endif

    for (genvar g = 0; g < MAX_CH; g++) begin : g_ch
        if (g < N_CH) begin : g_on
            rate_mon_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clk125MHz   (clk125MHz),
                .rstn        (rstn),
                .clear       (clear),
                .tick        (tick_s),
                .rx_en       (rx_en[g]),
                .rx_err      (rx_err[g]),
                .snap_bytes  (ch_bytes_s[g]),
                .snap_frames (ch_frames_s[g]),
`ifdef RATE_MON_PEAK_EN
                .snap_errs   (ch_errs_s[g]),
                .peak        (ch_peak_s[g])
`else
                .snap_errs   (ch_errs_s[g])
`endif
            );
        end else begin : g_off
            assign ch_bytes_s[g]  = {CNT_W{1'b0}};
            assign ch_frames_s[g] = {CNT_W{1'b0}};
            assign ch_errs_s[g]   = {CNT_W{1'b0}};
`ifdef RATE_MON_PEAK_EN
            assign ch_peak_s[g]   = {CNT_W{1'b0}};
`endif
        end
    end

    // Registered read mux.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            snap_bytes_r  <= {CNT_W{1'b0}};
            snap_frames_r <= {CNT_W{1'b0}};
            snap_errs_r   <= {CNT_W{1'b0}};
        end else if ({1'b0, rd_ch} < 5'(N_CH)) begin
            snap_bytes_r  <= ch_bytes_s[rd_ch];
            snap_frames_r <= ch_frames_s[rd_ch];
            snap_errs_r   <= ch_errs_s[rd_ch];
        end else begin
            snap_bytes_r  <= {CNT_W{1'b0}};
            snap_frames_r <= {CNT_W{1'b0}};
            snap_errs_r   <= {CNT_W{1'b0}};
        end
    end

`ifdef RATE_MON_PEAK_EN
    // Registered read of the peak register, same addressing as the snapshots.
    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            snap_peak_r <= {CNT_W{1'b0}};
        end else if ({1'b0, rd_ch} < 5'(N_CH)) begin
            snap_peak_r <= ch_peak_s[rd_ch];
        end else begin
            snap_peak_r <= {CNT_W{1'b0}};
        end
    end

    assign snap_peak = snap_peak_r;
`endif

    assign snap_bytes  = snap_bytes_r;
    assign snap_frames = snap_frames_r;
    assign snap_errs   = snap_errs_r;
    assign snap_valid  = snap_valid_r;
    assign window_done = window_done_r;

endmodule

// File: tb/tb_rx_rate_monitor.sv
// -----------------------------------------------------------------------------
// tb_rx_rate_monitor
// Directed bench for rx_rate_monitor with WINDOW_CYCLES=100, N_CH=2. dut
// uses CNT_W=8; dut6 (CNT_W=6) shares all inputs and shows saturation.
// Peak checks are compiled only when RATE_MON_PEAK_EN is defined.
// -----------------------------------------------------------------------------
module tb_rx_rate_monitor;

    localparam int N_CH = 2;
    localparam int WIN  = 100;

    logic       clk125MHz;
    logic       rstn;
    logic       clear;
    logic [1:0] rx_en;
    logic [1:0] rx_err;
    logic [3:0] rd_ch;

    logic [7:0] snap_bytes, snap_frames, snap_errs;
    logic       snap_valid, window_done;
    logic [5:0] snap_bytes6, snap_frames6, snap_errs6;
    logic       snap_valid6, window_done6;
`ifdef RATE_MON_PEAK_EN
    logic [7:0] snap_peak;
    logic [5:0] snap_peak6;
`endif

    int checks;
    int errors;
    int ncyc;

    typedef struct {
        logic [3:0] rd;
        int         bytes;
        int         frames;
        int         errs;
    } rd_vec_t;

    rd_vec_t tbl [5];

    rx_rate_monitor #(.N_CH(N_CH), .CNT_W(8), .WINDOW_CYCLES(WIN)) dut (
        .clk125MHz   (clk125MHz),
        .rstn        (rstn),
        .clear       (clear),
        .rx_en       (rx_en),
        .rx_err      (rx_err),
        .rd_ch       (rd_ch),
        .snap_bytes  (snap_bytes),
        .snap_frames (snap_frames),
        .snap_errs   (snap_errs),
`ifdef RATE_MON_PEAK_EN
        .snap_peak   (snap_peak),
`endif
        .snap_valid  (snap_valid),
        .window_done (window_done)
    );

    rx_rate_monitor #(.N_CH(N_CH), .CNT_W(6), .WINDOW_CYCLES(WIN)) dut6 (
        .clk125MHz   (clk125MHz),
        .rstn        (rstn),
        .clear       (clear),
        .rx_en       (rx_en),
        .rx_err      (rx_err),
        .rd_ch       (rd_ch),
        .snap_bytes  (snap_bytes6),
        .snap_frames (snap_frames6),
        .snap_errs   (snap_errs6),
`ifdef RATE_MON_PEAK_EN
        .snap_peak   (snap_peak6),
`endif
        .snap_valid  (snap_valid6),
        .window_done (window_done6)
    );

    // 125 MHz-style free-running clock.
    initial clk125MHz = 1'b0;
    always #5 clk125MHz = ~clk125MHz;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk125MHz);
        #1;
        ncyc++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Step until window_done is seen, bounded.
    task automatic wait_done(input string name);
        for (int k = 0; k < 3 * WIN; k++) begin
            step();
            if (window_done) return;
        end
        errors++;
        checks++;
        $display("FAIL %s: window_done got 0 expected 1 within %0d cycles", name, 3 * WIN);
    endtask

    task automatic send_frame(input int ch, input int len, input int err_idx);
        for (int k = 0; k < len; k++) begin
            rx_en[ch]  = 1'b1;
            rx_err[ch] = (k == err_idx);
            step();
        end
        rx_en[ch]  = 1'b0;
        rx_err[ch] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ncyc   = 0;
        rstn   = 1'b0;
        clear  = 1'b0;
        rx_en  = 2'b00;
        rx_err = 2'b00;
        rd_ch  = 4'd0;

        // ch1 traffic window read through the table
        tbl[0] = '{4'd1,  20, 2, 1};
        tbl[1] = '{4'd0,   0, 0, 0};
        tbl[2] = '{4'd2,   0, 0, 0};
        tbl[3] = '{4'd5,   0, 0, 0};
        tbl[4] = '{4'd15,  0, 0, 0};

        steps(3);
        chk("reset bytes", snap_bytes, 0);
        chk("reset frames", snap_frames, 0);
        chk("reset errs", snap_errs, 0);
        chk("reset valid", snap_valid, 0);
        chk("reset done", window_done, 0);
`ifdef RATE_MON_PEAK_EN
        chk("reset peak", snap_peak, 0);
`endif

        // Continuous ch0 traffic from reset release.
        rx_en = 2'b01;
        rstn  = 1'b1;
        ncyc  = 0;
        wait_done("t1 wait");
        chk("t1 done latency", ncyc, WIN);
        chk("t1 valid", snap_valid, 1);
        step();
        chk("t1 done width", window_done, 0);
        chk("t1 bytes", snap_bytes, 100);
        chk("t1 frames", snap_frames, 1);
        chk("t1 errs", snap_errs, 0);
        chk("t1 sat bytes", snap_bytes6, 63);
        chk("t1 sat frames", snap_frames6, 1);

        // Clear, then two 10-byte frames on ch1, the second errored.
        rx_en = 2'b00;
        clear = 1'b1;
        step();
        clear = 1'b0;
        ncyc  = 0;
        chk("t2 clear valid", snap_valid, 0);
        chk("t2 clear holds bytes", snap_bytes, 100);
        send_frame(1, 10, -1);
        steps(3);
        send_frame(1, 10, 5);
        wait_done("t2 wait");
        chk("t2 done latency", ncyc, WIN);
        chk("t2 valid", snap_valid, 1);
        for (int i = 0; i < 5; i++) begin
            rd_ch = tbl[i].rd;
            step();
            chk($sformatf("t2 rd%0d bytes", tbl[i].rd), snap_bytes, tbl[i].bytes);
            chk($sformatf("t2 rd%0d frames", tbl[i].rd), snap_frames, tbl[i].frames);
            chk($sformatf("t2 rd%0d errs", tbl[i].rd), snap_errs, tbl[i].errs);
        end

        // Frame on ch0 covering wcnt 95..104, error on its wcnt-97 byte.
        rd_ch = 4'd0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        steps(95);
        rx_en[0] = 1'b1;
        steps(2);
        rx_err[0] = 1'b1;
        step();
        rx_err[0] = 1'b0;
        steps(2);
        chk("t3 done at boundary", window_done, 1);
        step();
        chk("t3 w1 bytes", snap_bytes, 5);
        chk("t3 w1 frames", snap_frames, 1);
        chk("t3 w1 errs", snap_errs, 0);
        steps(4);
        rx_en[0] = 1'b0;
        wait_done("t3 wait");
        step();
        chk("t3 w2 bytes", snap_bytes, 5);
        chk("t3 w2 frames", snap_frames, 0);
        chk("t3 w2 errs", snap_errs, 1);

        // clear in the tick cycle: current cycle is wcnt 1, reach wcnt 99.
        steps(98);
        clear = 1'b1;
        step();
        clear = 1'b0;
        ncyc  = 0;
        chk("t4 no done", window_done, 0);
        chk("t4 valid cleared", snap_valid, 0);
        step();
        chk("t4 bytes held", snap_bytes, 5);
        chk("t4 errs held", snap_errs, 1);
        wait_done("t4 wait");
        chk("t4 next done latency", ncyc, WIN);
        step();
        chk("t4 idle window bytes", snap_bytes, 0);

`ifdef RATE_MON_PEAK_EN
        // Windows of 40, 70, 10 bytes on ch0.
        send_frame(0, 40, -1);
        wait_done("t5 w40 wait");
        step();
        chk("t5 peak 40", snap_peak, 40);
        chk("t5 peak6 40", snap_peak6, 40);
        send_frame(0, 70, -1);
        wait_done("t5 w70 wait");
        step();
        chk("t5 bytes 70", snap_bytes, 70);
        chk("t5 peak 70", snap_peak, 70);
        chk("t5 peak6 sat", snap_peak6, 63);
        send_frame(0, 10, -1);
        wait_done("t5 w10 wait");
        step();
        chk("t5 bytes 10", snap_bytes, 10);
        chk("t5 peak held", snap_peak, 70);
        chk("t5 peak6 held", snap_peak6, 63);
        rd_ch = 4'd5;
        step();
        chk("t5 rd5 peak", snap_peak, 0);
        chk("t5 rd5 bytes", snap_bytes, 0);
        chk("t5 rd5 frames", snap_frames, 0);
        chk("t5 rd5 errs", snap_errs, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
